// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and widths for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int SDRAM_HADDR_WIDTH = 24;
    localparam int SDRAM_DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_ISSUE = 2'd1,
        A_BUSY  = 2'd2
    } arb_state_t;

    function automatic int grant_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// rtl/sdram_arb_rr_pick.sv - combinational round-robin picker
module sdram_arb_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int GRANT_W   = 2
) (
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [GRANT_W-1:0]   last_grant,
    output logic                 pick_valid,
    output logic [GRANT_W-1:0]   pick_id
);

    int                 sum;
    logic [GRANT_W-1:0] idx;

    // Walk from the farthest offset down so the port nearest after last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        sum        = 0;
        idx        = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            sum = int'(last_grant) + i;
            if (sum >= NUM_PORTS) begin
                sum = sum - NUM_PORTS;
            end
            idx = GRANT_W'(sum);
            if (req_valid[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin share of one SDRAM controller host port; optional SDRAM_ARB_WATCHDOG_EN
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int HADDR_WIDTH = SDRAM_HADDR_WIDTH,
    parameter int DATA_WIDTH  = SDRAM_DATA_WIDTH,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]              req_ready,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic [grant_w(NUM_PORTS)-1:0]     grant_id,
    output logic                              err,
    output logic [HADDR_WIDTH-1:0]            ctrl_wr_addr,
    output logic [DATA_WIDTH-1:0]             ctrl_wr_data,
    output logic                              ctrl_wr_enable,
    output logic [HADDR_WIDTH-1:0]            ctrl_rd_addr,
    output logic                              ctrl_rd_enable,
    input  logic [DATA_WIDTH-1:0]             ctrl_rd_data,
    input  logic                              ctrl_rd_ready,
    input  logic                              ctrl_busy
);

    localparam int GRANT_W = grant_w(NUM_PORTS);

    arb_state_t             state_q, state_d;
    logic                   cap_we_q, cap_we_d;
    logic                   rd_seen_q, rd_seen_d;
    logic [GRANT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]     last_grant, next_ptr, grant_d;
    logic                   pick_valid;
    logic [GRANT_W-1:0]     pick_id;
    logic [NUM_PORTS-1:0]   req_ready_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_d, wr_data_d;
    logic [HADDR_WIDTH-1:0] wr_addr_d, rd_addr_d;
    logic                   wr_en_d, rd_en_d, err_d;
    logic                   wdog_hit;

    // rr_ptr is the first port to consider, so port 0 leads after reset.
    assign last_grant = (rr_ptr_q == '0) ? GRANT_W'(NUM_PORTS - 1) : rr_ptr_q - GRANT_W'(1);
    assign next_ptr   = (grant_id == GRANT_W'(NUM_PORTS - 1)) ? '0 : grant_id + GRANT_W'(1);

    sdram_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GRANT_W   (GRANT_W)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q;

    assign wdog_hit = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == A_IDLE || wdog_hit) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cap_we_d    = cap_we_q;
        rd_seen_d   = rd_seen_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_id;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data;
        wr_addr_d   = ctrl_wr_addr;
        wr_data_d   = ctrl_wr_data;
        rd_addr_d   = ctrl_rd_addr;
        wr_en_d     = ctrl_wr_enable;
        rd_en_d     = ctrl_rd_enable;
        err_d       = err;
        case (state_q)
            A_IDLE: begin
                if (pick_valid && !ctrl_busy) begin
                    cap_we_d             = req_we[pick_id];
                    rd_seen_d            = 1'b0;
                    grant_d              = pick_id;
                    req_ready_d[pick_id] = 1'b1;
                    if (req_we[pick_id]) begin
                        wr_addr_d = req_addr[pick_id*HADDR_WIDTH +: HADDR_WIDTH];
                        wr_data_d = req_wdata[pick_id*DATA_WIDTH +: DATA_WIDTH];
                        wr_en_d   = 1'b1;
                    end else begin
                        rd_addr_d = req_addr[pick_id*HADDR_WIDTH +: HADDR_WIDTH];
                        rd_en_d   = 1'b1;
                    end
                    state_d = A_ISSUE;
                end
            end
            // Busy stays low through controller init/refresh, so the enable simply waits.
            A_ISSUE: begin
                if (ctrl_busy) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    state_d = A_BUSY;
                end
            end
            A_BUSY: begin
                if (cap_we_q) begin
                    if (!ctrl_busy) begin
                        rsp_valid_d[grant_id] = 1'b1;
                        rr_ptr_d              = next_ptr;
                        state_d               = A_IDLE;
                    end
                end else begin
                    if (ctrl_rd_ready && !rd_seen_q) begin
                        rsp_data_d            = ctrl_rd_data;
                        rsp_valid_d[grant_id] = 1'b1;
                        rd_seen_d             = 1'b1;
                    end
                    if ((ctrl_rd_ready || rd_seen_q) && !ctrl_busy) begin
                        rr_ptr_d = next_ptr;
                        state_d  = A_IDLE;
                    end
                end
            end
            default: state_d = A_IDLE;
        endcase
        if (wdog_hit && state_q != A_IDLE) begin
            wr_en_d               = 1'b0;
            rd_en_d               = 1'b0;
            rsp_valid_d           = '0;
            rsp_valid_d[grant_id] = 1'b1;
            rsp_data_d            = '0;
            err_d                 = 1'b1;
            rr_ptr_d              = next_ptr;
            state_d               = A_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= A_IDLE;
            cap_we_q       <= 1'b0;
            rd_seen_q      <= 1'b0;
            rr_ptr_q       <= '0;
            grant_id       <= '0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            ctrl_wr_addr   <= '0;
            ctrl_wr_data   <= '0;
            ctrl_rd_addr   <= '0;
            ctrl_wr_enable <= 1'b0;
            ctrl_rd_enable <= 1'b0;
            err            <= 1'b0;
        end else begin
            state_q        <= state_d;
            cap_we_q       <= cap_we_d;
            rd_seen_q      <= rd_seen_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id       <= grant_d;
            req_ready      <= req_ready_d;
            rsp_valid      <= rsp_valid_d;
            rsp_data       <= rsp_data_d;
            ctrl_wr_addr   <= wr_addr_d;
            ctrl_wr_data   <= wr_data_d;
            ctrl_rd_addr   <= rd_addr_d;
            ctrl_wr_enable <= wr_en_d;
            ctrl_rd_enable <= rd_en_d;
            err            <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter with a behavioural controller
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int NP = 4, AW = 24, DW = 16, WDOG = 20;

    logic            clk, rst_n;
    logic [NP-1:0]   req_valid, req_we, req_ready, rsp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, ctrl_wr_data, ctrl_rd_data;
    logic [1:0]      grant_id;
    logic            err, ctrl_wr_enable, ctrl_rd_enable, ctrl_rd_ready, ctrl_busy;
    logic [AW-1:0]   ctrl_wr_addr, ctrl_rd_addr;

    sdram_port_arbiter #(.NUM_PORTS(NP), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .grant_id(grant_id), .err(err), .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data),
        .ctrl_wr_enable(ctrl_wr_enable), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_enable(ctrl_rd_enable),
        .ctrl_rd_data(ctrl_rd_data), .ctrl_rd_ready(ctrl_rd_ready), .ctrl_busy(ctrl_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: stalls stall_cfg enable cycles (init/refresh), then busy for 3 cycles.
    int            stall_cfg, m_cnt, m_stall;
    bit            same_cfg, never_cfg, m_active, m_we;
    logic [DW-1:0] m_val;
    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        if (!rst_n) begin
            ctrl_busy <= 1'b0; ctrl_rd_ready <= 1'b0; ctrl_rd_data <= '0;
            m_active <= 1'b0; m_cnt <= 0; m_stall <= 0; m_we <= 1'b0; m_val <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= {i[7:0], ~i[7:0]};
            mem[8'h45] <= 16'hBEEF;
        end else begin
            ctrl_rd_ready <= 1'b0;
            if (m_active) begin
                if (m_cnt == 1) begin
                    ctrl_busy <= 1'b0; m_active <= 1'b0;
                    if (!m_we && same_cfg) begin ctrl_rd_ready <= 1'b1; ctrl_rd_data <= m_val; end
                end else begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 2 && !m_we && !same_cfg) begin ctrl_rd_ready <= 1'b1; ctrl_rd_data <= m_val; end
                end
            end else if (ctrl_rd_enable || ctrl_wr_enable) begin
                if (never_cfg) m_stall <= m_stall;
                else if (m_stall != 0) m_stall <= m_stall - 1;
                else begin
                    ctrl_busy <= 1'b1; m_active <= 1'b1; m_cnt <= 3; m_we <= ctrl_wr_enable;
                    if (ctrl_wr_enable) mem[ctrl_wr_addr[7:0]] <= ctrl_wr_data;
                    else m_val <= mem[ctrl_rd_addr[7:0]];
                end
            end else begin
                m_stall <= stall_cfg;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    typedef struct { int port; bit we; logic [DW-1:0] data; } sb_t;
    sb_t           sb[$];
    int            gseq[$];
    bit            exp_we [NP];
    logic [DW-1:0] exp_dat [NP];
    logic [DW-1:0] exp_wd [NP];
    logic [AW-1:0] exp_adr [NP];
    int            cyc = 0, fall_cyc = 0, en_run = 0, last_run = 0, cur_port = 0;

    initial forever begin @(posedge clk); cyc++; end

    // Monitor: scoreboard push on capture, pop on response, bus protocol checks every cycle.
    initial begin
        bit en, prev_en, prev_busy;
        logic [63:0] prev_bus;
        sb_t e;
        prev_en = 0; prev_busy = 0; prev_bus = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                en = ctrl_rd_enable | ctrl_wr_enable;
                if (en) chk("en_excl", 64'(ctrl_rd_enable & ctrl_wr_enable), 64'd0);
                for (int p = 0; p < NP; p++) begin
                    if (req_ready[p]) begin
                        chk("grant_id", 64'(grant_id), 64'(p));
                        sb.push_back('{p, exp_we[p], exp_dat[p]});
                        gseq.push_back(p);
                        cur_port = p;
                    end
                end
                if (en && !prev_en) begin
                    if (exp_we[cur_port]) begin
                        chk("wr_addr", 64'(ctrl_wr_addr), 64'(exp_adr[cur_port]));
                        chk("wr_data", 64'(ctrl_wr_data), 64'(exp_wd[cur_port]));
                        chk("wr_en", 64'(ctrl_wr_enable), 64'd1);
                    end else begin
                        chk("rd_addr", 64'(ctrl_rd_addr), 64'(exp_adr[cur_port]));
                        chk("rd_en", 64'(ctrl_rd_enable), 64'd1);
                    end
                end
                if (en && prev_en) chk("addr_stable", {ctrl_rd_addr, ctrl_wr_addr, ctrl_wr_data}, prev_bus);
                if (en) en_run++;
                else if (prev_en) begin last_run = en_run; en_run = 0; end
                if (prev_busy && !ctrl_busy) fall_cyc = cyc;
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp actual=%0h required=0", rsp_valid);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_port", 64'(rsp_valid), 64'd1 << e.port);
                        if (!e.we) chk("rsp_data", 64'(rsp_data), 64'(e.data));
                        else chk("wr_rsp_lat", 64'(cyc - fall_cyc), 64'd1);
                    end
                end
                prev_en = en; prev_busy = ctrl_busy;
                prev_bus = {ctrl_rd_addr, ctrl_wr_addr, ctrl_wr_data};
            end else begin
                prev_en = 0; prev_busy = 0; en_run = 0;
            end
        end
    end

    task automatic wait_ready(input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (req_ready[p]) return;
        end
        checks++; errors++;
        $display("FAIL req_ready_timeout actual=0 required=1 port=%0d", p);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) return;
        end
        checks++; errors++;
        $display("FAIL rsp_timeout actual=%0d required=0 pending", sb.size());
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] ed);
        exp_we[p] = we; exp_adr[p] = a; exp_wd[p] = wd; exp_dat[p] = ed;
        req_we[p] = we; req_addr[p*AW +: AW] = a; req_wdata[p*DW +: DW] = wd;
    endtask

    typedef struct {
        int port; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp; int stall; bit same;
    } vec_t;
    vec_t vt [6];

    initial begin
        int n0;
        vt[0] = '{1, 1'b0, 24'h012345, 16'h0000, 16'hBEEF, 0, 1'b0};
        vt[1] = '{0, 1'b1, 24'h000010, 16'hA5A5, 16'h0000, 0, 1'b0};
        vt[2] = '{2, 1'b0, 24'h000010, 16'h0000, 16'hA5A5, 3, 1'b1};
        vt[3] = '{3, 1'b1, 24'h00ABCD, 16'h1357, 16'h0000, 5, 1'b0};
        vt[4] = '{3, 1'b0, 24'h00ABCD, 16'h0000, 16'h1357, 0, 1'b1};
        vt[5] = '{0, 1'b0, 24'h000220, 16'h0000, 16'h20DF, 2, 1'b0};
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        stall_cfg = 0; same_cfg = 0; never_cfg = 0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_host", 64'({req_ready, rsp_valid, rsp_data, grant_id, err}), 64'd0);
        chk("reset_ctrl", 64'({ctrl_wr_enable, ctrl_rd_enable, ctrl_wr_addr, ctrl_rd_addr}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        foreach (vt[i]) begin
            stall_cfg = vt[i].stall; same_cfg = vt[i].same;
            set_port(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);
            req_valid[vt[i].port] = 1'b1;
            wait_ready(vt[i].port, 50);
            req_valid[vt[i].port] = 1'b0;
            wait_drain(100);
            chk("en_hold", 64'(last_run), 64'(vt[i].stall + 2));
            repeat (2) @(negedge clk);
            #1;
        end

        // A request that disappears before it is captured must leave no trace.
        stall_cfg = 4; same_cfg = 0;
        set_port(0, 1'b0, 24'h000020, '0, 16'h20DF);
        set_port(2, 1'b0, 24'h000031, '0, 16'h31CE);
        n0 = gseq.size();
        req_valid[0] = 1'b1;
        wait_ready(0, 50);
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_drain(100);
        repeat (5) @(negedge clk);
        #1;
        chk("dropped_req", 64'(gseq.size()), 64'(n0 + 1));

        // Reset while the controller is busy with a read.
        stall_cfg = 0;
        set_port(1, 1'b0, 24'h000045, '0, 16'hBEEF);
        req_valid[1] = 1'b1;
        wait_ready(1, 50);
        req_valid[1] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (ctrl_busy && !ctrl_rd_enable) break;
        end
        chk("in_busy", 64'(ctrl_busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_host", 64'({req_ready, rsp_valid, rsp_data, grant_id, err}), 64'd0);
        chk("rst_mid_ctrl", 64'({ctrl_wr_enable, ctrl_rd_enable, ctrl_wr_addr, ctrl_rd_addr}), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;

        // All ports valid continuously: grants must rotate 0,1,2,3,0.
        for (int p = 0; p < NP; p++) begin
            logic [7:0] lo;
            lo = 8'h31 + 8'(p);
            set_port(p, 1'b0, {16'h0, lo}, '0, {lo, ~lo});
        end
        n0 = gseq.size();
        req_valid = '1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (gseq.size() >= n0 + 5) break;
        end
        req_valid = '0;
        chk("rr_count", 64'(gseq.size()), 64'(n0 + 5));
        for (int k = 0; k < 5; k++) begin
            if (gseq.size() > n0 + k) chk("rr_order", 64'(gseq[n0 + k]), 64'(k % NP));
        end
        wait_drain(100);
        repeat (3) @(negedge clk);
        #1;

`ifdef SDRAM_ARB_WATCHDOG_EN
        never_cfg = 1;
        set_port(2, 1'b0, 24'h000020, '0, 16'h0000);
        req_valid[2] = 1'b1;
        wait_ready(2, 50);
        req_valid[2] = 1'b0;
        wait_drain(100);
        chk("wdog_en_cycles", 64'(last_run), 64'(WDOG));
        chk("wdog_err", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("wdog_err_sticky", 64'(err), 64'd1);
        never_cfg = 0;
`else
        chk("err_tied", 64'(err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
